// File: rtl/wrapper_req_ctrl_pkg.sv
// Shared definitions for the request-routing register block.
// Latency: n/a (constants, types and a width helper only).
// Backpressure: n/a.
package wrapper_req_ctrl_pkg;

  // Byte addresses of the register map
  localparam logic [11:0] ADDR_DREQ_EN     = 12'h000;
  localparam logic [11:0] ADDR_DREQ_EN_SET = 12'h004;
  localparam logic [11:0] ADDR_DREQ_EN_CLR = 12'h008;
  localparam logic [11:0] ADDR_REQ_ACT     = 12'h010;
  localparam logic [11:0] ADDR_IRQ_STATUS  = 12'h014;
  localparam logic [11:0] ADDR_IRQ_MASK    = 12'h018;
  localparam logic [11:0] ADDR_IRQ_MODE    = 12'h01C;
  localparam logic [11:0] ADDR_IRQ_MASKED  = 12'h020;
  localparam logic [11:0] ADDR_HOLD_ACT    = 12'h024;

  // Returned for idle reads, write-only registers and unmapped addresses
  localparam logic [31:0] RDATA_BAD = 32'h0bad0bad;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  // Hold-off counter width: enough bits to hold HOLDOFF, never less than one
  function automatic int hold_cnt_width(input int holdoff);
    return (holdoff <= 1) ? 1 : $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/wrapper_req_ch.sv
// One request channel: edge detect, sticky irq status, dma_done hold-off counter.
// Latency: drq combinational from req_act; status/hold state update on the next hclk edge.
// Backpressure: none; dma_done forces drq low for HOLDOFF cycles.
// Ports:
//   hclk, hreset            clock, synchronous active-high reset
//   req_act, dma_done       channel request line and DMAC completion pulse
//   drq_en, irq_mode,
//   irq_mask, status_clr    shared register bits for this channel, W1C strobe
//   drq, irq, status,
//   hold_act                channel outputs and read-back state
module wrapper_req_ch
  import wrapper_req_ctrl_pkg::*;
#(
  parameter int HOLDOFF = 2
) (
  input  logic      hclk,
  input  logic      hreset,
  input  logic      req_act,
  input  logic      dma_done,
  input  logic      drq_en,
  input  irq_mode_e irq_mode,
  input  logic      irq_mask,
  input  logic      status_clr,
  output logic      drq,
  output logic      irq,
  output logic      status,
  output logic      hold_act
);

  localparam int CW = hold_cnt_width(HOLDOFF);
  // With HOLDOFF = 0 the load value is zero, so dma_done has no effect
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF);

  logic          req_q, req_d;
  logic          status_q, status_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          set_req;

  always_comb begin
    req_d      = req_act;
    set_req    = ~drq_en & ((irq_mode == IRQ_EDGE) ? (req_act & ~req_q) : req_act);
    // Set takes priority over a same-cycle write-1-to-clear
    status_d   = set_req | (status_q & ~status_clr);
    hold_cnt_d = hold_cnt_q;
    if (dma_done) begin
      hold_cnt_d = HOLD_LOAD;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      req_q      <= 1'b0;
      status_q   <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      req_q      <= req_d;
      status_q   <= status_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign drq      = req_act & drq_en & (hold_cnt_q == '0);
  assign irq      = status_q & irq_mask;
  assign status   = status_q;
  assign hold_act = (hold_cnt_q != '0);

endmodule

// File: rtl/wrapper_req_ctrl_nch.sv
// Routes NUM_CH request lines to DMA requests or sticky maskable interrupts.
// Latency: zero-latency reads; writes take effect at the hclk edge with write_en high.
// Backpressure: none on the register bus; drq held off for HOLDOFF cycles after dma_done.
// Ports:
//   hclk, hreset                          clock, synchronous active-high reset
//   addr, read_en, write_en, wdata, rdata register interface (rdata combinational)
//   req_act, dma_done                     per-channel request and DMAC completion
//   drq, irq, irq_merged                  DMA requests, interrupts, OR of interrupts
module wrapper_req_ctrl_nch
  import wrapper_req_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 32,
  parameter int NUM_CH    = 5,
  parameter int HOLDOFF   = 2
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] rdata,
  input  logic [NUM_CH-1:0]    req_act,
  input  logic [NUM_CH-1:0]    dma_done,
  output logic [NUM_CH-1:0]    drq,
  output logic [NUM_CH-1:0]    irq,
  output logic                 irq_merged
);

  logic [NUM_CH-1:0] drq_en_q, drq_en_d;
  logic [NUM_CH-1:0] irq_mask_q, irq_mask_d;
  logic [NUM_CH-1:0] irq_mode_q, irq_mode_d;
  logic [NUM_CH-1:0] status_clr;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] hold_act;
  logic [NUM_CH-1:0] wd;

  assign wd = wdata[NUM_CH-1:0];

  always_comb begin
    drq_en_d   = drq_en_q;
    irq_mask_d = irq_mask_q;
    irq_mode_d = irq_mode_q;
    status_clr = '0;
    if (write_en) begin
      case (addr)
        ADDRWIDTH'(ADDR_DREQ_EN):     drq_en_d   = wd;
        ADDRWIDTH'(ADDR_DREQ_EN_SET): drq_en_d   = drq_en_q | wd;
        ADDRWIDTH'(ADDR_DREQ_EN_CLR): drq_en_d   = drq_en_q & ~wd;
        ADDRWIDTH'(ADDR_IRQ_STATUS):  status_clr = wd;
        ADDRWIDTH'(ADDR_IRQ_MASK):    irq_mask_d = wd;
        ADDRWIDTH'(ADDR_IRQ_MODE):    irq_mode_d = wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      drq_en_q   <= '0;
      irq_mask_q <= '1;
      irq_mode_q <= '0;
    end else begin
      drq_en_q   <= drq_en_d;
      irq_mask_q <= irq_mask_d;
      irq_mode_q <= irq_mode_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wrapper_req_ch #(.HOLDOFF(HOLDOFF)) u_ch (
      .hclk       (hclk),
      .hreset     (hreset),
      .req_act    (req_act[i]),
      .dma_done   (dma_done[i]),
      .drq_en     (drq_en_q[i]),
      .irq_mode   (irq_mode_e'(irq_mode_q[i])),
      .irq_mask   (irq_mask_q[i]),
      .status_clr (status_clr[i]),
      .drq        (drq[i]),
      .irq        (irq[i]),
      .status     (status[i]),
      .hold_act   (hold_act[i])
    );
  end

  assign irq_merged = |irq;

  // Reads see pre-edge register state, so a same-cycle write never shows through
  always_comb begin
    rdata = DATAWIDTH'(RDATA_BAD);
    if (read_en) begin
      case (addr)
        ADDRWIDTH'(ADDR_DREQ_EN):    begin rdata = '0; rdata[NUM_CH-1:0] = drq_en_q;            end
        ADDRWIDTH'(ADDR_REQ_ACT):    begin rdata = '0; rdata[NUM_CH-1:0] = req_act;             end
        ADDRWIDTH'(ADDR_IRQ_STATUS): begin rdata = '0; rdata[NUM_CH-1:0] = status;              end
        ADDRWIDTH'(ADDR_IRQ_MASK):   begin rdata = '0; rdata[NUM_CH-1:0] = irq_mask_q;          end
        ADDRWIDTH'(ADDR_IRQ_MODE):   begin rdata = '0; rdata[NUM_CH-1:0] = irq_mode_q;          end
        ADDRWIDTH'(ADDR_IRQ_MASKED): begin rdata = '0; rdata[NUM_CH-1:0] = status & irq_mask_q; end
        ADDRWIDTH'(ADDR_HOLD_ACT):   begin rdata = '0; rdata[NUM_CH-1:0] = hold_act;            end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wrapper_req_ctrl_nch.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_wrapper_req_ctrl_nch;
  import wrapper_req_ctrl_pkg::*;

  localparam int K_RD = 0, K_DRQ = 1, K_IRQ = 2, K_MRG = 3,
                 K_RD1 = 4, K_DRQ1 = 5, K_RD32 = 6, K_DRQ32 = 7, K_IRQ32 = 8;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [11:0] addr = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata5, rdata1, rdata32;
  logic [4:0]  req_act5 = '0, dma_done5 = '0, drq5, irq5;
  logic [0:0]  req_act1 = '0, dma_done1 = '0, drq1, irq1;
  logic [31:0] req_act32 = '0, dma_done32 = '0, drq32, irq32;
  logic        irq_merged5, irq_merged1, irq_merged32;

  always #5 hclk = ~hclk;

  wrapper_req_ctrl_nch #(.ADDRWIDTH(12), .DATAWIDTH(32), .NUM_CH(5), .HOLDOFF(2)) u_dut5 (
    .hclk(hclk), .hreset(hreset), .addr(addr), .read_en(read_en), .write_en(write_en),
    .wdata(wdata), .rdata(rdata5), .req_act(req_act5), .dma_done(dma_done5),
    .drq(drq5), .irq(irq5), .irq_merged(irq_merged5));

  wrapper_req_ctrl_nch #(.ADDRWIDTH(12), .DATAWIDTH(32), .NUM_CH(1), .HOLDOFF(2)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .addr(addr), .read_en(read_en), .write_en(write_en),
    .wdata(wdata), .rdata(rdata1), .req_act(req_act1), .dma_done(dma_done1),
    .drq(drq1), .irq(irq1), .irq_merged(irq_merged1));

  wrapper_req_ctrl_nch #(.ADDRWIDTH(12), .DATAWIDTH(32), .NUM_CH(32), .HOLDOFF(2)) u_dut32 (
    .hclk(hclk), .hreset(hreset), .addr(addr), .read_en(read_en), .write_en(write_en),
    .wdata(wdata), .rdata(rdata32), .req_act(req_act32), .dma_done(dma_done32),
    .drq(drq32), .irq(irq32), .irq_merged(irq_merged32));

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [31:0] mon_act;
  logic mon_vld = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      K_RD:    return rdata5;
      K_DRQ:   return 32'(drq5);
      K_IRQ:   return 32'(irq5);
      K_MRG:   return 32'(irq_merged5);
      K_RD1:   return rdata1;
      K_DRQ1:  return 32'(drq1);
      K_RD32:  return rdata32;
      K_DRQ32: return drq32;
      K_IRQ32: return irq32;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  always @(negedge hclk) begin
    if (mon_vld) begin
      while (sb_q.size() != 0) begin
        mon_e   = sb_q.pop_front();
        mon_act = sample(mon_e.kind);
        chk_cnt++;
        if (mon_act === mon_e.exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic push(input string nm, input int kind, input logic [31:0] e);
    exp_t x;
    x.name = nm; x.kind = kind; x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // One observed cycle: the monitor consumes everything pushed for it at the negedge
  task automatic cyc();
    mon_vld = 1'b1;
    tick();
    mon_vld = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    addr = a; wdata = d; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] e);
    addr = a; read_en = 1'b1;
    push(nm, K_RD, e);
    cyc();
    read_en = 1'b0;
  endtask

  logic [4:0] ho1_dd  [5] = '{5'h10, 5'h00, 5'h00, 5'h00, 5'h00};
  logic [4:0] ho1_drq [5] = '{5'h10, 5'h00, 5'h00, 5'h10, 5'h10};
  logic [4:0] ho2_dd  [6] = '{5'h10, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00};
  logic [4:0] ho2_drq [6] = '{5'h10, 5'h00, 5'h00, 5'h00, 5'h10, 5'h10};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] es;
    tick(); tick();
    hreset = 1'b0;
    tick();

    // Post-reset outputs and idle read value
    addr = ADDR_DREQ_EN;
    push("rst_drq", K_DRQ, 32'h0);
    push("rst_irq", K_IRQ, 32'h0);
    push("rst_merged", K_MRG, 32'h0);
    push("idle_read_bad", K_RD, 32'h0bad0bad);
    cyc();

    // Build traffic: status 0x0A, then drq_en 0x1F
    req_act5 = 5'h0A;
    tick();
    req_act5 = 5'h00;
    wr(ADDR_DREQ_EN, 32'h1F);
    req_act5 = 5'h1F;
    push("traffic_drq", K_DRQ, 32'h1F);
    push("traffic_irq", K_IRQ, 32'h0A);
    rd("traffic_status", ADDR_IRQ_STATUS, 32'h0A);

    // Mid-traffic reset
    hreset = 1'b1;
    tick();
    push("midrst_drq", K_DRQ, 32'h0);
    push("midrst_irq", K_IRQ, 32'h0);
    push("midrst_merged", K_MRG, 32'h0);
    rd("midrst_dreq_en", ADDR_DREQ_EN, 32'h0);
    rd("midrst_mask", ADDR_IRQ_MASK, 32'h1F);
    rd("midrst_mode", ADDR_IRQ_MODE, 32'h0);
    rd("midrst_status", ADDR_IRQ_STATUS, 32'h0);
    rd("unmapped_0fc", 12'h0FC, 32'h0bad0bad);
    req_act5 = 5'h00;
    hreset = 1'b0;
    tick();

    // DREQ_EN set/clear
    wr(ADDR_DREQ_EN_SET, 32'h5);
    wr(ADDR_DREQ_EN_CLR, 32'h4);
    rd("dreq_en_setclr", ADDR_DREQ_EN, 32'h1);
    rd("set_reg_reads_bad", ADDR_DREQ_EN_SET, 32'h0bad0bad);
    req_act5 = 5'h05;
    push("setclr_drq", K_DRQ, 32'h01);
    rd("req_act_raw", ADDR_REQ_ACT, 32'h05);
    rd("setclr_status", ADDR_IRQ_STATUS, 32'h04);
    req_act5 = 5'h00;
    wr(ADDR_IRQ_STATUS, 32'h04);
    rd("setclr_status_w1c", ADDR_IRQ_STATUS, 32'h0);
    wr(ADDR_DREQ_EN, 32'h0);

    // Edge mode on channel 1: one capture, W1C at cycle 5 stays cleared
    wr(ADDR_IRQ_MODE, 32'h02);
    for (int k = 0; k < 10; k++) begin
      req_act5 = 5'h02;
      addr     = ADDR_IRQ_STATUS;
      read_en  = 1'b1;
      write_en = (k == 5);
      wdata    = 32'h02;
      es = (k >= 1 && k <= 5) ? 32'h02 : 32'h0;
      push($sformatf("edge_status_c%0d", k), K_RD, es);
      push($sformatf("edge_irq_c%0d", k), K_IRQ, es);
      push($sformatf("edge_merged_c%0d", k), K_MRG, 32'(es != 0));
      cyc();
    end
    write_en = 1'b0; read_en = 1'b0; req_act5 = 5'h00;
    wr(ADDR_IRQ_MODE, 32'h0);

    // Level mode: set wins over W1C, then masking
    req_act5 = 5'h08;
    tick();
    wr(ADDR_IRQ_STATUS, 32'h08);
    rd("level_set_wins", ADDR_IRQ_STATUS, 32'h08);
    wr(ADDR_IRQ_MASK, 32'h17);
    push("masked_irq", K_IRQ, 32'h0);
    push("masked_merged", K_MRG, 32'h0);
    rd("irq_masked_reg", ADDR_IRQ_MASKED, 32'h0);
    rd("masked_status_kept", ADDR_IRQ_STATUS, 32'h08);
    req_act5 = 5'h00;
    wr(ADDR_IRQ_STATUS, 32'h08);
    wr(ADDR_IRQ_MASK, 32'h1F);
    rd("level_cleared", ADDR_IRQ_STATUS, 32'h0);

    // Hold-off on channel 4: single and back-to-back dma_done
    wr(ADDR_DREQ_EN, 32'h10);
    req_act5 = 5'h10;
    for (int k = 0; k < 5; k++) begin
      dma_done5 = ho1_dd[k];
      addr = ADDR_HOLD_ACT; read_en = 1'b1;
      push($sformatf("hold1_drq_t%0d", k), K_DRQ, 32'(ho1_drq[k]));
      push($sformatf("hold1_act_t%0d", k), K_RD, (ho1_drq[k] == 5'h0) ? 32'h10 : 32'h0);
      cyc();
    end
    for (int k = 0; k < 6; k++) begin
      dma_done5 = ho2_dd[k];
      addr = ADDR_HOLD_ACT; read_en = 1'b1;
      push($sformatf("hold2_drq_t%0d", k), K_DRQ, 32'(ho2_drq[k]));
      push($sformatf("hold2_act_t%0d", k), K_RD, (ho2_drq[k] == 5'h0) ? 32'h10 : 32'h0);
      cyc();
    end
    read_en = 1'b0; dma_done5 = '0; req_act5 = '0;
    rd("hold_status_untouched", ADDR_IRQ_STATUS, 32'h0);

    // Width sweep across 5, 1 and 32 channels
    wr(ADDR_IRQ_MASK, 32'hFFFF_FFFF);
    wr(ADDR_DREQ_EN, 32'h5555_5555);
    req_act5 = '1; req_act1 = '1; req_act32 = '1;
    push("sweep_drq5", K_DRQ, 32'h15);
    push("sweep_drq1", K_DRQ1, 32'h1);
    push("sweep_drq32", K_DRQ32, 32'h5555_5555);
    cyc();
    addr = ADDR_IRQ_STATUS; read_en = 1'b1;
    push("sweep_status5", K_RD, 32'h0A);
    push("sweep_status1", K_RD1, 32'h0);
    push("sweep_status32", K_RD32, 32'hAAAA_AAAA);
    push("sweep_irq32", K_IRQ32, 32'hAAAA_AAAA);
    cyc();
    read_en = 1'b0;
    tick();

    chk_cnt++;
    if (sb_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
